spi_arbiter: RTL and testbench

SPI_ARBITER -- requirements
Module: spi_arbiter

---
 rtl/spi_pkg.sv | 24 ++
 rtl/arb_timeout_cnt.sv | 30 +++
 rtl/spi_arbiter.sv | 146 ++++++++++++++
 tb/tb_spi_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: definitions shared by the SPI bus arbiter and its testbench.
//   arb_state_e      - arbiter FSM states (idle, owned by requester 0/1, gap)
//   TIMEOUT_CYC_DEF  - default maximum grant hold, in clk cycles (100 ms @ 10 MHz)
//   GAP_CYC_DEF      - default idle cycles forced between successive owners
//   SPI_BUSY_BIT     - bit of the SPI master read data that flags a transfer in flight
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2,
        ST_GAP  = 2'd3
    } arb_state_e;

    localparam int unsigned TIMEOUT_CYC_DEF = 1_000_000;
    localparam int unsigned GAP_CYC_DEF     = 2;
    localparam int unsigned SPI_BUSY_BIT    = 0;

    // One-hot vector for a two-requester index.
    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/arb_timeout_cnt.sv
// arb_timeout_cnt: grant-hold watchdog for the SPI arbiter.
//   clk_i      - system clock
//   reset_i    - synchronous active-high reset
//   clear_i    - zero the count (held while the bus is not owned)
//   enable_i   - count this cycle (bus owned)
//   limit_i    - hold limit in cycles
//   expired_o  - high during the owned cycle whose count reaches limit_i-1,
//                i.e. the limit_i-th owned cycle
module arb_timeout_cnt (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        clear_i,
    input  logic        enable_i,
    input  logic [31:0] limit_i,
    output logic        expired_o
);

    logic [31:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            cnt_q <= '0;
        end else if (enable_i) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign expired_o = enable_i && (cnt_q == limit_i - 32'd1);

endmodule

// File: rtl/spi_arbiter.sv
// spi_arbiter: two-requester round-robin arbiter in front of one SPI master.
//   clk_i, reset_i          - clock, synchronous active-high reset
//   req_i[1:0]              - bus requests (bit 0 = CPU, bit 1 = sensor controller)
//   wr_i, reg_sel_i         - per-requester write strobe / register select
//   addr0_i/addr1_i         - per-requester address
//   data0_i/data1_i         - per-requester write data
//   gnt_o[1:0]              - registered one-hot grant
//   err_o[1:0]              - registered one-cycle timeout pulse
//   rdata_o                 - SPI read data forwarded to the owner only
//   spi_wr_o, spi_reg_sel_o,
//   spi_addr_o, spi_data_o  - owner's request forwarded to the SPI master
//   spi_rdata_i             - SPI master read data, bit SPI_BUSY_BIT = busy
// A grant is held for at most TIMEOUT_CYC cycles; a timed-out requester gets
// err_o in the following cycle and stays ineligible until it drops req_i.
// Every hand-over passes through at least GAP_CYC idle cycles and waits for
// the SPI master to go non-busy.
module spi_arbiter
    import spi_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int unsigned GAP_CYC     = GAP_CYC_DEF
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [1:0]  req_i,
    input  logic [1:0]  wr_i,
    input  logic [1:0]  reg_sel_i,
    input  logic [9:0]  addr0_i,
    input  logic [9:0]  addr1_i,
    input  logic [31:0] data0_i,
    input  logic [31:0] data1_i,
    output logic [1:0]  gnt_o,
    output logic [1:0]  err_o,
    output logic [31:0] rdata_o,
    output logic        spi_wr_o,
    output logic        spi_reg_sel_o,
    output logic [9:0]  spi_addr_o,
    output logic [31:0] spi_data_o,
    input  logic [31:0] spi_rdata_i
);

    // Last gap_q value of the minimum gap; a zero/one gap still lasts one cycle.
    localparam logic [31:0] GAP_LAST = (GAP_CYC > 1) ? 32'(GAP_CYC - 1) : 32'd0;

    arb_state_e  state_q;
    logic        ptr_q;
    logic [1:0]  mask_q;
    logic [1:0]  gnt_q;
    logic [1:0]  err_q;
    logic [31:0] gap_q;

    logic        owned;
    logic        owner;
    logic        own_req;
    logic        expired;
    logic        timeout_hit;
    logic        gap_done;
    logic        busy;
    logic        pick1;
    logic [1:0]  eligible;
    logic [1:0]  mask_set;

    always_comb begin
        owned       = (state_q == ST_OWN0) || (state_q == ST_OWN1);
        owner       = (state_q == ST_OWN1);
        own_req     = owned && req_i[owner];
        eligible    = req_i & ~mask_q;
        // Requester 1 wins when it is the only one eligible or the pointer favours it.
        pick1       = eligible[1] && (!eligible[0] || ptr_q);
        // A release in the expiring cycle takes precedence over the timeout.
        timeout_hit = own_req && expired;
        mask_set    = timeout_hit ? onehot2(owner) : 2'b00;
        busy        = spi_rdata_i[SPI_BUSY_BIT];
        gap_done    = (gap_q >= GAP_LAST);
    end

    arb_timeout_cnt u_timeout (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .clear_i   (!owned),
        .enable_i  (owned),
        .limit_i   (32'(TIMEOUT_CYC)),
        .expired_o (expired)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            ptr_q   <= 1'b0;
            mask_q  <= 2'b00;
            gnt_q   <= 2'b00;
            err_q   <= 2'b00;
            gap_q   <= '0;
        end else begin
            // A mask clears once its requester has been seen low for a cycle.
            mask_q <= (mask_q & req_i) | mask_set;
            err_q  <= mask_set;
            case (state_q)
                ST_IDLE: begin
                    if (|eligible) begin
                        state_q <= pick1 ? ST_OWN1 : ST_OWN0;
                        gnt_q   <= onehot2(pick1);
                    end
                end
                ST_OWN0, ST_OWN1: begin
                    if (!own_req || timeout_hit) begin
                        state_q <= ST_GAP;
                        gnt_q   <= 2'b00;
                        ptr_q   <= !owner;
                        gap_q   <= '0;
                    end
                end
                ST_GAP: begin
                    // Past the minimum gap, leave only when the SPI master is idle.
                    if (gap_done) begin
                        if (!busy) begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        gap_q <= gap_q + 32'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        gnt_o         = gnt_q;
        err_o         = err_q;
        spi_wr_o      = 1'b0;
        spi_reg_sel_o = 1'b0;
        spi_addr_o    = '0;
        spi_data_o    = '0;
        rdata_o       = '0;
        if (owned) begin
            // A strobe coinciding with the request drop is not forwarded.
            spi_wr_o      = wr_i[owner] && req_i[owner];
            spi_reg_sel_o = reg_sel_i[owner];
            spi_addr_o    = owner ? addr1_i : addr0_i;
            spi_data_o    = owner ? data1_i : data0_i;
            rdata_o       = spi_rdata_i;
        end
    end

endmodule

// File: tb/tb_spi_arbiter.sv
module tb_spi_arbiter;

    localparam int TMO = 16;
    localparam int GAP = 2;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic [1:0]  req_i = 2'b00;
    logic [1:0]  wr_i = 2'b00;
    logic [1:0]  reg_sel_i = 2'b00;
    logic [9:0]  addr0_i = '0;
    logic [9:0]  addr1_i = '0;
    logic [31:0] data0_i = '0;
    logic [31:0] data1_i = '0;
    logic [31:0] spi_rdata_i = '0;
    logic [1:0]  gnt_o;
    logic [1:0]  err_o;
    logic [31:0] rdata_o;
    logic        spi_wr_o;
    logic        spi_reg_sel_o;
    logic [9:0]  spi_addr_o;
    logic [31:0] spi_data_o;

    int n_tests = 0;
    int n_fail  = 0;

    spi_arbiter #(.TIMEOUT_CYC(TMO), .GAP_CYC(GAP)) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .req_i         (req_i),
        .wr_i          (wr_i),
        .reg_sel_i     (reg_sel_i),
        .addr0_i       (addr0_i),
        .addr1_i       (addr1_i),
        .data0_i       (data0_i),
        .data1_i       (data1_i),
        .gnt_o         (gnt_o),
        .err_o         (err_o),
        .rdata_o       (rdata_o),
        .spi_wr_o      (spi_wr_o),
        .spi_reg_sel_o (spi_reg_sel_o),
        .spi_addr_o    (spi_addr_o),
        .spi_data_o    (spi_data_o),
        .spi_rdata_i   (spi_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Who owns the bus (-1 = nobody), how long it has owned it, whether the
    // bus is in the hand-over gap and for how long, round-robin favourite,
    // timed-out requesters and the pending error pulse.
    int       m_owner = -1;
    int       m_owned = 0;
    bit       m_in_gap = 0;
    int       m_gap = 0;
    bit       m_ptr = 0;
    bit [1:0] m_mask = 0;
    bit [1:0] m_err = 0;
    bit       started = 0;

    always @(posedge clk) begin
        bit [1:0] elig;
        elig = req_i & ~m_mask;
        if (reset_i) begin
            m_owner = -1; m_owned = 0; m_in_gap = 0; m_gap = 0;
            m_ptr = 0; m_mask = 0; m_err = 0; started = 1;
        end else begin
            m_err = 0;
            for (int i = 0; i < 2; i++) if (!req_i[i]) m_mask[i] = 0;
            if (m_owner >= 0) begin
                m_owned++;
                if (!req_i[m_owner]) begin
                    m_ptr = (m_owner == 0);
                    m_owner = -1; m_in_gap = 1; m_gap = 0;
                end else if (m_owned == TMO) begin
                    m_err[m_owner] = 1;
                    m_mask[m_owner] = 1;
                    m_ptr = (m_owner == 0);
                    m_owner = -1; m_in_gap = 1; m_gap = 0;
                end
            end else if (m_in_gap) begin
                m_gap++;
                if (m_gap >= GAP && !spi_rdata_i[0]) m_in_gap = 0;
            end else if (elig != 2'b00) begin
                if (elig == 2'b11) m_owner = int'(m_ptr);
                else m_owner = elig[1] ? 1 : 0;
                m_owned = 0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        bit       own;
        int       oi;
        if (started) begin
            own = (m_owner >= 0);
            oi  = own ? m_owner : 0;
            chk("gnt",     32'(gnt_o), own ? (oi == 1 ? 32'd2 : 32'd1) : 32'd0);
            chk("err",     32'(err_o), 32'(m_err));
            chk("spi_wr",  32'(spi_wr_o), 32'(own && wr_i[oi] && req_i[oi]));
            chk("reg_sel", 32'(spi_reg_sel_o), 32'(own && reg_sel_i[oi]));
            chk("addr",    32'(spi_addr_o), !own ? 32'd0 : (oi == 1 ? 32'(addr1_i) : 32'(addr0_i)));
            chk("data",    spi_data_o, !own ? 32'd0 : (oi == 1 ? data1_i : data0_i));
            chk("rdata",   rdata_o, own ? spi_rdata_i : 32'd0);
            chk("gnt_not_11", 32'(gnt_o == 2'b11), 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus with literal checks ----------------
    initial begin
        spi_rdata_i = 32'hABCD_0000;
        tick(); tick();
        chk("rst_gnt", 32'(gnt_o), 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        reset_i = 0;

        // Single request from idle, write forwarding.
        req_i = 2'b01;
        tick();
        chk("grant0_lat1", 32'(gnt_o), 32'd1);
        wr_i = 2'b11; reg_sel_i = 2'b01; addr0_i = 10'h155; data0_i = 32'h0000_0013;
        addr1_i = 10'h2AA; data1_i = 32'hDEAD_BEEF;
        #1;
        chk("wr_fwd", 32'(spi_wr_o), 32'd1);
        chk("data_fwd", spi_data_o, 32'h13);
        chk("addr_fwd", 32'(spi_addr_o), 32'h155);
        chk("rdata_fwd", rdata_o, 32'hABCD_0000);
        tick(); tick();
        // Strobe in the same cycle the request drops is blocked.
        req_i = 2'b00; wr_i = 2'b01;
        #1;
        chk("wr_on_drop", 32'(spi_wr_o), 32'd0);
        tick();
        chk("gap_gnt", 32'(gnt_o), 32'd0);
        wr_i = 2'b00;
        tick(); tick(); tick();

        // Simultaneous requests from reset: requester 0 first, then 1 after gap.
        reset_i = 1; tick(); reset_i = 0;
        req_i = 2'b11;
        tick();
        chk("both_first", 32'(gnt_o), 32'd1);
        tick(); tick(); tick();
        req_i = 2'b10; wr_i = 2'b10;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("gap_no_gnt", 32'(gnt_o), 32'd0);
            chk("gap_no_wr", 32'(spi_wr_o), 32'd0);
        end
        tick();
        chk("second_owner", 32'(gnt_o), 32'd2);
        wr_i = 2'b00;

        // Owner 1 drops while SPI busy: gap stretched until busy clears.
        req_i = 2'b01; spi_rdata_i = 32'h0000_0001;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("busy_hold", 32'(gnt_o), 32'd0);
            chk("busy_rdata", rdata_o, 32'd0);
        end
        spi_rdata_i = 32'h0;
        tick();
        chk("busy_idle", 32'(gnt_o), 32'd0);
        tick();
        chk("after_busy", 32'(gnt_o), 32'd1);

        // Timeout: owner 0 holds for TMO cycles.
        req_i = 2'b11;
        repeat (TMO - 1) tick();
        chk("tmo_last_own", 32'(gnt_o), 32'd1);
        chk("tmo_no_err", 32'(err_o), 32'd0);
        tick();
        chk("tmo_err", 32'(err_o), 32'd1);
        chk("tmo_drop", 32'(gnt_o), 32'd0);
        tick();
        chk("tmo_err_1cyc", 32'(err_o), 32'd0);
        tick();
        chk("tmo_idle", 32'(gnt_o), 32'd0);
        tick();
        chk("tmo_other", 32'(gnt_o), 32'd2);
        req_i = 2'b01;
        repeat (3) tick();
        tick();
        chk("masked", 32'(gnt_o), 32'd0);
        tick();
        chk("masked2", 32'(gnt_o), 32'd0);
        req_i = 2'b00; tick();
        req_i = 2'b01; tick();
        chk("unmasked", 32'(gnt_o), 32'd1);

        // Reset mid-transfer by owner 1.
        req_i = 2'b00;
        reset_i = 1; tick(); reset_i = 0;
        req_i = 2'b10;
        tick();
        chk("own1", 32'(gnt_o), 32'd2);
        wr_i = 2'b10; reg_sel_i = 2'b10; addr1_i = 10'h3FF; data1_i = 32'hCAFE_0001;
        req_i = 2'b11; spi_rdata_i = 32'h55AA_0000;
        #1;
        chk("own1_wr", 32'(spi_wr_o), 32'd1);
        chk("own1_data", spi_data_o, 32'hCAFE_0001);
        reset_i = 1;
        tick();
        chk("rst_mid_gnt", 32'(gnt_o), 32'd0);
        chk("rst_mid_wr", 32'(spi_wr_o), 32'd0);
        chk("rst_mid_data", spi_data_o, 32'd0);
        chk("rst_mid_addr", 32'(spi_addr_o), 32'd0);
        chk("rst_mid_rdata", rdata_o, 32'd0);
        reset_i = 0;
        tick();
        chk("rst_regrant", 32'(gnt_o), 32'd1);
        chk("rst_regrant_wr", 32'(spi_wr_o), 32'd0);

        req_i = 2'b00; wr_i = 2'b00;
        repeat (4) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
